// File: rtl/timer_prescaler.sv
// rtl/timer_prescaler.sv - programmable tick/clock-enable prescaler with shadowed ratio load
// Optional one-shot mode (oneshot port, DONE state) under TIMER_PRESCALER_ONESHOT_EN.
module timer_prescaler #(
   parameter int DIV_W         = 8,
   parameter int DEFAULT_RATIO = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             clear,
   input  logic             ratio_setting,
   input  logic [DIV_W-1:0] divide_ratio,
`ifdef TIMER_PRESCALER_ONESHOT_EN
   input  logic             oneshot,
`endif
   output logic             tick,
   output logic             clk_o,
   output logic [DIV_W-1:0] ratio_active,
   output logic             pending
);

`ifdef TIMER_PRESCALER_ONESHOT_EN
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`else
   typedef enum logic [1:0] {IDLE, RUN} state_t;
`endif

   state_t           state, nxt_state;
   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] shadow;
   logic [DIV_W-1:0] eff_m1;
   logic [DIV_W-1:0] load_src;
   logic             in_done;
   logic             count_en;
   logic             terminal;
   logic             apply;
   logic             shot_done;

   // A ratio of 0 behaves as 1, so the terminal count is simply 0.
   assign eff_m1   = (ratio_active == '0) ? '0 : ratio_active - DIV_W'(1);
`ifdef TIMER_PRESCALER_ONESHOT_EN
   assign in_done   = (state == DONE);
`else
   assign in_done   = 1'b0;
`endif
   assign count_en = en && !clear && !in_done;
   // >= guards against a smaller ratio loaded while paused mid-period.
   assign terminal = count_en && (cnt >= eff_m1);
`ifdef TIMER_PRESCALER_ONESHOT_EN
   assign shot_done = oneshot && terminal;
`else
   assign shot_done = 1'b0;
`endif
   assign load_src = ratio_setting ? divide_ratio : shadow;
   assign apply    = (pending || ratio_setting) && (terminal || (state == IDLE) || clear);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= nxt_state;
   end

   always_comb begin
      nxt_state = state;
      case (state)
         IDLE: if (!clear && en) nxt_state = shot_done ? state_t'(2) : RUN;
         RUN: begin
            if (!clear) begin
               if (!en)            nxt_state = IDLE;
               else if (shot_done) nxt_state = state_t'(2);
            end
         end
`ifdef TIMER_PRESCALER_ONESHOT_EN
         DONE: begin
            if (clear)    nxt_state = en ? RUN : IDLE;
            else if (!en) nxt_state = IDLE;
         end
`endif
         default: nxt_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt          <= '0;
         tick         <= 1'b0;
         clk_o        <= 1'b0;
         pending      <= 1'b0;
         shadow       <= '0;
         ratio_active <= DIV_W'(DEFAULT_RATIO);
      end else begin
         if (apply) begin
            ratio_active <= load_src;
            pending      <= 1'b0;
         end else if (ratio_setting) begin
            shadow  <= divide_ratio;
            pending <= 1'b1;
         end

         if (clear) begin
            cnt   <= '0;
            tick  <= 1'b0;
            clk_o <= 1'b0;
         end else if (in_done) begin
            cnt  <= '0;
            tick <= 1'b0;
         end else if (count_en) begin
            if (terminal) begin
               cnt   <= '0;
               tick  <= 1'b1;
               clk_o <= ~clk_o;
            end else begin
               cnt  <= cnt + DIV_W'(1);
               tick <= 1'b0;
            end
         end else begin
            tick <= 1'b0;
         end
      end
   end

endmodule

// File: doc/timer_prescaler.md
Name: timer_prescaler

Overview:
- Programmable tick generator sitting directly upstream of the timer counter.
- Divides the system clock by a runtime-loadable ratio and emits a one-cycle `tick` enable plus a toggling `clk_o` level.
- The counter consumes these single-clock-domain signals in place of a derived clock.
- Ratio changes are shadowed and applied only at a period boundary, so the counter never sees a truncated period.

Parameters:
- DIV_W, 8, width of the divide ratio and internal count.
- DEFAULT_RATIO, 1, active ratio after reset.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  run enable; low pauses the count.
- clear  input  1  synchronous restart of the current period.
- ratio_setting  input  1  one-cycle strobe that captures divide_ratio.
- divide_ratio  input  DIV_W  requested ratio N; 0 is treated as 1.
- tick  output  1  registered one-cycle pulse, one per N enabled cycles.
- clk_o  output  1  registered level that toggles on every tick (period 2N).
- ratio_active  output  DIV_W  ratio currently in force.
- pending  output  1  a captured ratio is waiting for the period boundary.

Behaviour:
- Reset (reset low, asynchronous):
  - cnt=0, tick=0, clk_o=0, pending=0, ratio_active=DEFAULT_RATIO, state=IDLE.
- States:
  - IDLE: en low or just out of reset. cnt holds its value; tick=0.
  - RUN: en high.
  - IDLE->RUN on the first edge with en=1. RUN->IDLE on the first edge with en=0.
  - Pausing preserves cnt, so resuming continues the same period.
- Counting in RUN, with eff = max(ratio_active,1):
  - cnt==eff-1: cnt<=0, tick<=1, clk_o<=~clk_o.
  - Otherwise: cnt<=cnt+1, tick<=0.
- Latency: with en high from edge 0 and cnt=0, tick is high in the cycles after edges N-1, 2N-1, 3N-1, …
  - N=1 (or 0): tick is high every cycle after the first enabled edge; clk_o toggles every cycle.
- Ratio load:
  - ratio_setting=1 captures divide_ratio into a shadow register and sets pending=1.
  - The shadow transfers to ratio_active, and pending clears, on the next edge where any of these hold:
    - the terminal count is hit (the new ratio applies to the very next period);
    - state is IDLE;
    - clear=1.
  - ratio_setting in the same cycle as the terminal count applies immediately at that edge.
  - A second ratio_setting before the transfer overwrites the shadow (last write wins).
- clear:
  - Priority over en and the terminal count.
  - Sets cnt=0, tick=0, clk_o=0; applies any pending ratio.
  - State is unchanged.
- Arithmetic: cnt is DIV_W wide with no wrap beyond eff-1; eff is always ≥ 1.
- Reset mid-period: everything returns to reset values immediately, without waiting for a clock edge. The pending ratio is lost.

Optional Feature:
- Macro: TIMER_PRESCALER_ONESHOT_EN.
- When defined:
  - Adds input `oneshot` (1 bit) and a DONE state.
  - In RUN with oneshot=1, the first tick moves the FSM to DONE.
  - DONE: cnt=0, tick=0, clk_o held.
  - DONE is left only via clear=1 (to RUN if en=1, else IDLE) or via en falling (to IDLE).
- When undefined: no `oneshot` port, no DONE state, and the block is free-running only.

Test Plan:
- Reset low for 3 cycles, then high, en=1, no ratio load -> ratio_active=1, tick high every cycle from the cycle after the first enabled edge, clk_o toggling every cycle.
- ratio_setting with divide_ratio=4 while IDLE, then en=1 for 12 edges -> pending=0 the cycle after the strobe, ratio_active=4; tick high after edges 3, 7, 11; clk_o high after 3, low after 7, high after 11.
- Running at N=4, load divide_ratio=2 at edge 1 -> pending=1 until edge 3 (the terminal count); tick after edge 3, then after edges 5 and 7.
- N=5 with en dropped for 3 cycles after edge 2 -> cnt holds 3 during the pause; tick occurs 2 enabled edges after resume, not a full 5.
- clear at edge 2 of an N=3 period while ratio_setting is active with divide_ratio=0 -> cnt=0, clk_o=0, ratio_active=0 (eff=1), tick every enabled cycle thereafter.
- TIMER_PRESCALER_ONESHOT_EN defined, oneshot=1, N=3, en=1 -> exactly one tick (after edge 2), then no ticks for 10 cycles; clear -> ticks resume one-shot after 3 more enabled edges.
